mdr_shift_add_mult: RTL and testbench

- Sequential unsigned shift-and-add multiplier in the MDR datapath.
- Sits directly downstream of the left-shift register stage.
- Loads that stage with the multiplicand, steps it one bit-shift per cycle, and accumulates its output whenever the current multiplier LSB is 1.
- Produces a 2*DW-bit product with a start/done handshake.

---
 rtl/mdr_shift_add_mult_pkg.sv | 14 +
 rtl/mdr_shift_add_mult.sv | 102 ++++++++++
 tb/tb_mdr_shift_add_mult.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdr_shift_add_mult_pkg.sv
// Shared MDR datapath types: operand width, multiplier FSM states, product type.
package pkg_system_mdr;

  localparam int MDR_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdr_mult_state_e;

  typedef logic [2*MDR_DW-1:0] mdr_prod_t;

endpackage

// File: rtl/mdr_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier driving an external shift-left-by-1 stage.
// Optional build macro MDR_MULT_EARLY_EXIT_EN ends the run once no multiplier bits remain.
module mdr_shift_add_mult
  import pkg_system_mdr::*;
#(
  parameter int DW = MDR_DW,
  parameter int PW = 2 * DW,
  parameter int CW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_multiplicand,
  input  logic [DW-1:0] i_multiplier,
  input  logic [PW-1:0] i_shl_val,
  output logic [PW-1:0] o_shl_load_val,
  output logic          o_shl_init,
  output logic          o_shl_enable,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic [PW-1:0] o_product
);

  mdr_mult_state_e state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic            last_iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    mplier_d       = mplier_q;
    cnt_d          = cnt_q;
    product_d      = product_q;
    o_shl_load_val = '0;
    o_shl_init     = 1'b0;
    o_shl_enable   = 1'b0;
    last_iter      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          mplier_d       = i_multiplier;
          o_shl_load_val = {{(PW-DW){1'b0}}, i_multiplicand};
          o_shl_init     = 1'b1;
          acc_d          = '0;
          cnt_d          = '0;
          state_d        = RUN;
        end
      end
      RUN: begin
        // i_shl_val already holds multiplicand << cnt_q this cycle
        o_shl_enable = 1'b1;
        if (mplier_q[0]) begin
          acc_d = acc_q + i_shl_val;
        end
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q + 1'b1;
        last_iter = (cnt_q == CW'(DW-1));
`ifdef MDR_MULT_EARLY_EXIT_EN
        if (mplier_d == '0) begin
          last_iter = 1'b1;
        end
`endif
        if (last_iter) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_ready   = (state_q == IDLE);
  assign o_busy    = (state_q == RUN) || (state_q == DONE);
  assign o_done    = (state_q == DONE);
  assign o_product = product_q;

endmodule

// File: tb/tb_mdr_shift_add_mult.sv
// Directed and random checks of mdr_shift_add_mult (DW=8) with a behavioural left shifter alongside.
module tb_mdr_shift_add_mult;

  localparam int DW = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_multiplicand = '0;
  logic [DW-1:0] i_multiplier = '0;
  logic [PW-1:0] shl_q = '0;
  logic [PW-1:0] o_shl_load_val;
  logic          o_shl_init;
  logic          o_shl_enable;
  logic          o_ready;
  logic          o_busy;
  logic          o_done;
  logic [PW-1:0] o_product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // External shift-left-by-1 stage fed back into the multiplier
  always_ff @(posedge clk) begin
    if (o_shl_init) shl_q <= o_shl_load_val;
    else if (o_shl_enable) shl_q <= shl_q << 1;
  end

  mdr_shift_add_mult #(.DW(DW), .PW(PW), .CW(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_multiplicand(i_multiplicand),
    .i_multiplier  (i_multiplier),
    .i_shl_val     (shl_q),
    .o_shl_load_val(o_shl_load_val),
    .o_shl_init    (o_shl_init),
    .o_shl_enable  (o_shl_enable),
    .o_ready       (o_ready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_product     (o_product)
  );

  function automatic int exp_lat(input logic [DW-1:0] b);
    int idx;
    idx = -1;
    for (int i = 0; i < DW; i++) if (b[i]) idx = i;
`ifdef MDR_MULT_EARLY_EXIT_EN
    return (idx < 0) ? 2 : idx + 2;
`else
    return (idx < -1) ? 0 : DW + 1;
`endif
  endfunction

  // One multiply: start accepted in cycle 0, latency counted in cycles after it.
  task automatic op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit hold,
                    input logic [DW-1:0] ha, input logic [DW-1:0] hb,
                    output logic [PW-1:0] prod, output int lat, output int en_cnt,
                    output bit init_extra, output bit en_at_done,
                    output logic [PW-1:0] prod_c1, output bit rdy0, output bit done_after);
    @(posedge clk); #1;
    i_start = 1'b1; i_multiplicand = a; i_multiplier = b;
    @(negedge clk);
    rdy0 = o_ready && o_shl_init && !o_shl_enable && (o_shl_load_val === {8'h00, a});
    @(posedge clk); #1;
    if (hold) begin
      i_multiplicand = ha; i_multiplier = hb;
    end else begin
      i_start = 1'b0;
    end
    lat = -1; en_cnt = 0; init_extra = 1'b0; en_at_done = 1'b0;
    prod = '0; prod_c1 = '0; done_after = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) prod_c1 = o_product;
      if (o_shl_init) init_extra = 1'b1;
      if (o_done) begin
        lat = k; prod = o_product; en_at_done = o_shl_enable;
        break;
      end
      if (o_shl_enable) en_cnt++;
      @(posedge clk); #1;
    end
    if (!hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      done_after = o_done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({o_product, o_ready, o_busy, o_done} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_status: got prod=%0h rdy=%0b busy=%0b done=%0b, want 0/1/0/0",
               o_product, o_ready, o_busy, o_done);
    end
    n_checks++;
    if ({o_shl_init, o_shl_enable, o_shl_load_val} !== {1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_shl: got init=%0b en=%0b load=%0h, want 0/0/0",
               o_shl_init, o_shl_enable, o_shl_load_val);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [PW-1:0] p, pc1;
    int lat, en;
    bit ie, ead, r0, da;
    op(8'd7, 8'd9, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if (p !== 16'd63) begin n_fail++; $display("FAIL basic_product: got %0d want 63", p); end
    n_checks++;
    if (lat !== exp_lat(8'd9)) begin
      n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat(8'd9));
    end
    n_checks++;
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL basic_init_cycle0: got %0b want 1", r0); end
    n_checks++;
    if (ie !== 1'b0) begin n_fail++; $display("FAIL basic_init_once: got %0b want 0", ie); end
    n_checks++;
    if (en !== lat - 1) begin
      n_fail++; $display("FAIL basic_enable_cycles: got %0d want %0d", en, lat - 1);
    end
    n_checks++;
    if (ead !== 1'b0) begin n_fail++; $display("FAIL basic_enable_in_done: got %0b want 0", ead); end
    n_checks++;
    if (da !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %0b want 0", da); end
  endtask

  task automatic test_boundary();
    logic [PW-1:0] p, pc1;
    int lat, en;
    bit ie, ead, r0, da;
    op(8'd255, 8'd255, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if (p !== 16'hFE01) begin n_fail++; $display("FAIL max_product: got %0h want fe01", p); end
    n_checks++;
    if (lat !== 9) begin n_fail++; $display("FAIL max_latency: got %0d want 9", lat); end
    op(8'd0, 8'd200, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if (p !== 16'd0) begin n_fail++; $display("FAIL zero_product: got %0d want 0", p); end
    n_checks++;
    if (lat !== exp_lat(8'd200)) begin
      n_fail++; $display("FAIL zero_latency: got %0d want %0d", lat, exp_lat(8'd200));
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] p, pc1;
    int lat, en;
    bit ie, ead, r0, da;
    op(8'd3, 8'd5, 1'b1, 8'd10, 8'd10, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if (p !== 16'd15) begin n_fail++; $display("FAIL b2b_first: got %0d want 15", p); end
    n_checks++;
    if (ie !== 1'b0) begin n_fail++; $display("FAIL b2b_start_ignored: got %0b want 0", ie); end
    op(8'd10, 8'd10, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_ready: got %0b want 1", r0); end
    n_checks++;
    if (pc1 !== 16'd15) begin n_fail++; $display("FAIL b2b_product_held: got %0d want 15", pc1); end
    n_checks++;
    if (p !== 16'd100) begin n_fail++; $display("FAIL b2b_second: got %0d want 100", p); end
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] p, pc1;
    int lat, en, dones;
    bit ie, ead, r0, da;
    @(posedge clk); #1;
    i_start = 1'b1; i_multiplicand = 8'd100; i_multiplier = 8'd100;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_product !== 16'd100) begin
      n_fail++; $display("FAIL midrst_held_before: got %0d want 100", o_product);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_product, o_busy, o_ready, o_done} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_state: got prod=%0d busy=%0b rdy=%0b done=%0b, want 0/0/1/0",
               o_product, o_busy, o_ready, o_done);
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
    op(8'd2, 8'd3, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if (p !== 16'd6) begin n_fail++; $display("FAIL midrst_after: got %0d want 6", p); end
  endtask

`ifdef MDR_MULT_EARLY_EXIT_EN
  task automatic test_early_exit();
    logic [PW-1:0] p, pc1;
    int lat, en;
    bit ie, ead, r0, da;
    op(8'd200, 8'd1, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if ({p, lat} !== {16'd200, 32'd2}) begin
      n_fail++; $display("FAIL early_200x1: got prod=%0d lat=%0d want 200/2", p, lat);
    end
    op(8'd1, 8'd128, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if ({p, lat} !== {16'd128, 32'd9}) begin
      n_fail++; $display("FAIL early_1x128: got prod=%0d lat=%0d want 128/9", p, lat);
    end
    op(8'd5, 8'd0, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
    n_checks++;
    if ({p, lat} !== {16'd0, 32'd2}) begin
      n_fail++; $display("FAIL early_5x0: got prod=%0d lat=%0d want 0/2", p, lat);
    end
  endtask
`endif

  task automatic test_random();
    logic [PW-1:0] p, pc1, want;
    logic [DW-1:0] a, b;
    int lat, en;
    bit ie, ead, r0, da;
    for (int n = 0; n < 1000; n++) begin
      a = DW'($urandom_range(0, 255));
      b = DW'($urandom_range(0, 255));
      want = PW'(a) * PW'(b);
      op(a, b, 1'b0, 8'd0, 8'd0, p, lat, en, ie, ead, pc1, r0, da);
      n_checks++;
      if ({p, lat, da} !== {want, exp_lat(b), 1'b0}) begin
        n_fail++;
        $display("FAIL rand_%0dx%0d: got prod=%0d lat=%0d done_after=%0b want %0d/%0d/0",
                 a, b, p, lat, da, want, exp_lat(b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
`ifdef MDR_MULT_EARLY_EXIT_EN
    test_early_exit();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
